mrd_frame_tx: RTL and testbench

//  Frame transmitter feeding the mixed-radix DFT memory sink (mrd_st_if input side).

---
 rtl/mrd_frame_tx.sv | 150 +++++++++++++++
 tb/tb_mrd_frame_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrd_frame_tx.sv
// Frame transmitter: buffers complex samples in a FIFO and emits one contiguous
// sop..eop burst of cfg_dftpts samples toward the DFT memory sink when it is idle.
//
//   state | meaning
//   IDLE  | waiting for a full frame, an idle memory and a valid frame length
//   SEND  | popping one sample per cycle until out_dftpts samples have left
//   GAP   | enforcing GAP_CYC idle cycles before the next frame may start
module mrd_frame_tx #(
    parameter int DEPTH   = 2048,
    parameter int AW      = 11,
    parameter int GAP_CYC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [11:0]   cfg_dftpts,
    input  logic          in_valid,
    input  logic [17:0]   in_real,
    input  logic [17:0]   in_imag,
    output logic          in_ready,
    input  logic          mem_idle,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    output logic [17:0]   out_real,
    output logic [17:0]   out_imag,
    output logic [11:0]   out_dftpts,
    output logic          busy,
    output logic [AW:0]   fifo_level,
    output logic          ovf_err,
    output logic          cfg_err
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q;
    logic [11:0]     cnt_q;
    logic [GW-1:0]   gap_q;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [35:0]     mem_q [DEPTH];
    logic [35:0]     rd_data;

    logic            push, pop, cfg_ok, start;

    assign in_ready   = 32'(level_q) < 32'(DEPTH);
    assign push       = in_valid & in_ready;
    assign pop        = (state_q == ST_SEND);
    assign rd_data    = mem_q[rd_ptr_q];

    assign cfg_ok     = (cfg_dftpts != 12'd0) && (32'(cfg_dftpts) <= 32'(DEPTH));
    assign cfg_err    = !cfg_ok && (state_q == ST_IDLE);
    assign start      = (state_q == ST_IDLE) && mem_idle && cfg_ok
                        && (32'(level_q) >= 32'(cfg_dftpts));

    assign busy       = (state_q != ST_IDLE);
    assign fifo_level = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Sample storage carries no reset; only pointers and level define contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_real, in_imag};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_err  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (in_valid && !in_ready) ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_real   <= '0;
            out_imag   <= '0;
            out_dftpts <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    out_sop   <= 1'b0;
                    out_eop   <= 1'b0;
                    if (start) begin
                        state_q    <= ST_SEND;
                        out_dftpts <= cfg_dftpts;
                        cnt_q      <= 12'd1;
                    end
                end
                ST_SEND: begin
                    out_valid <= 1'b1;
                    out_sop   <= (cnt_q == 12'd1);
                    out_eop   <= (cnt_q == out_dftpts);
                    out_real  <= rd_data[35:18];
                    out_imag  <= rd_data[17:0];
                    cnt_q     <= cnt_q + 12'd1;
                    if (cnt_q == out_dftpts) begin
                        state_q <= ST_GAP;
                        gap_q   <= GW'(GAP_CYC - 1);
                    end
                end
                ST_GAP: begin
                    out_valid <= 1'b0;
                    out_sop   <= 1'b0;
                    out_eop   <= 1'b0;
                    if (gap_q == '0) state_q <= ST_IDLE;
                    else             gap_q   <= gap_q - GW'(1);
                end
                default: begin
                    state_q   <= ST_IDLE;
                    out_valid <= 1'b0;
                    out_sop   <= 1'b0;
                    out_eop   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mrd_frame_tx.sv
// Bench for mrd_frame_tx: directed stimulus queues expected samples, a negedge
// monitor pops and compares whenever out_valid is high.
module tb_mrd_frame_tx;
    localparam int DEPTH   = 2048;
    localparam int AW      = 11;
    localparam int GAP_CYC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [11:0]   cfg_dftpts = 12'd12;
    logic          in_valid = 1'b0;
    logic [17:0]   in_real = '0;
    logic [17:0]   in_imag = '0;
    logic          in_ready;
    logic          mem_idle = 1'b0;
    logic          out_valid, out_sop, out_eop;
    logic [17:0]   out_real, out_imag;
    logic [11:0]   out_dftpts;
    logic          busy;
    logic [AW:0]   fifo_level;
    logic          ovf_err, cfg_err;

    always #5 clk = ~clk;

    mrd_frame_tx #(.DEPTH(DEPTH), .AW(AW), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_dftpts(cfg_dftpts),
        .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag), .in_ready(in_ready),
        .mem_idle(mem_idle), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_real(out_real), .out_imag(out_imag), .out_dftpts(out_dftpts), .busy(busy),
        .fifo_level(fifo_level), .ovf_err(ovf_err), .cfg_err(cfg_err)
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [11:0] dftpts;
        logic [17:0] re;
        logic [17:0] im;
    } smp_t;

    smp_t exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0;
    int   valid_cnt = 0, sop_cnt = 0, sop_cyc = -1, last_eop_cyc = 0;
    bit   have_eop = 0, in_burst = 0, mon_en = 0;
    smp_t mon_got, mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!mon_en) begin
            in_burst = 0;
            have_eop = 0;
        end else if (out_valid) begin
            mon_got = {out_sop, out_eop, out_dftpts, out_real, out_imag};
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sample", 64'(mon_got), 64'(mon_exp));
            end
            if (out_sop) begin
                sop_cnt++;
                sop_cyc = cyc;
                if (have_eop) chk("min_gap", 64'((cyc - last_eop_cyc - 1) >= GAP_CYC), 64'd1);
                in_burst = 1;
            end
            if (out_eop) begin
                in_burst = 0;
                have_eop = 1;
                last_eop_cyc = cyc;
            end
        end else begin
            chk("idle_flags", {out_sop, out_eop}, 64'd0);
            if (in_burst) begin
                chk("burst_contig", 64'(out_valid), 64'd1);
                in_burst = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int base, input int n);
        smp_t e;
        for (int k = 0; k < n; k++) begin
            e.sop    = (k == 0);
            e.eop    = (k == n - 1);
            e.dftpts = 12'(n);
            e.re     = 18'(base + k);
            e.im     = 18'(-(base + k));
            exp_q.push_back(e);
        end
    endtask

    task automatic push_stream(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_real  = 18'(base + k);
            in_imag  = 18'(-(base + k));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int i;
        for (i = 0; i < budget && (exp_q.size() != 0 || busy); i++) tick();
        chk({name, "_queue"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        mon_en   = 0;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1;
    endtask

    int v0, s0, c;

    initial begin
        tick();
        tick();
        chk("rst_outs", {out_valid, out_sop, out_eop, out_real, out_imag, out_dftpts}, 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_busy_ovf", {busy, ovf_err}, 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst_n  = 1'b1;
        mon_en = 1;

        // 1: one full 1200-sample frame
        cfg_dftpts = 12'd1200;
        mem_idle   = 1'b1;
        v0 = valid_cnt;
        expect_frame(0, 1200);
        push_stream(0, 1200);
        drain(3000, "t1_drain");
        chk("t1_count", 64'(valid_cnt - v0), 64'd1200);
        chk("t1_level", 64'(fifo_level), 64'd0);

        // 2: 30 samples, two 12-sample frames, 6 left over
        do_reset();
        cfg_dftpts = 12'd12;
        mem_idle   = 1'b1;
        s0 = sop_cnt;
        expect_frame(100, 12);
        expect_frame(112, 12);
        push_stream(100, 30);
        drain(200, "t2_drain");
        repeat (40) tick();
        chk("t2_frames", 64'(sop_cnt - s0), 64'd2);
        chk("t2_level", 64'(fifo_level), 64'd6);

        // 3: mem_idle gating and sop latency
        do_reset();
        cfg_dftpts = 12'd12;
        mem_idle   = 1'b0;
        v0 = valid_cnt;
        expect_frame(300, 12);
        push_stream(300, 12);
        repeat (20) tick();
        chk("t3_held", 64'(valid_cnt - v0), 64'd0);
        chk("t3_level", 64'(fifo_level), 64'd12);
        mem_idle = 1'b1;
        c  = cyc;
        s0 = sop_cnt;
        for (int i = 0; i < 10 && sop_cnt == s0; i++) tick();
        chk("t3_sop_cyc", 64'(sop_cyc), 64'(c + 2));
        mem_idle = 1'b0;
        drain(100, "t3_drain");
        chk("t3_count", 64'(valid_cnt - v0), 64'd12);

        // 4: overflow
        do_reset();
        cfg_dftpts = 12'd2048;
        mem_idle   = 1'b0;
        expect_frame(1000, 2048);
        push_stream(1000, 2048);
        chk("t4_ready", 64'(in_ready), 64'd0);
        chk("t4_level_full", 64'(fifo_level), 64'd2048);
        chk("t4_ovf_pre", 64'(ovf_err), 64'd0);
        push_stream(50000, 3);
        chk("t4_ovf", 64'(ovf_err), 64'd1);
        chk("t4_level_ovf", 64'(fifo_level), 64'd2048);
        mem_idle = 1'b1;
        drain(2500, "t4_drain");
        chk("t4_level_end", 64'(fifo_level), 64'd0);
        chk("t4_ovf_sticky", 64'(ovf_err), 64'd1);

        // 5: invalid lengths and mid-frame cfg change
        do_reset();
        mem_idle   = 1'b1;
        cfg_dftpts = 12'd0;
        #1;
        chk("t5_err_zero", 64'(cfg_err), 64'd1);
        s0 = sop_cnt;
        push_stream(400, 5);
        repeat (10) tick();
        chk("t5_busy_zero", 64'(busy), 64'd0);
        cfg_dftpts = 12'd2049;
        #1;
        chk("t5_err_big", 64'(cfg_err), 64'd1);
        repeat (10) tick();
        chk("t5_nosop", 64'(sop_cnt - s0), 64'd0);
        cfg_dftpts = 12'd12;
        #1;
        chk("t5_err_ok", 64'(cfg_err), 64'd0);
        v0 = valid_cnt;
        expect_frame(400, 12);
        push_stream(405, 7);
        for (int i = 0; i < 20 && (valid_cnt - v0) < 3; i++) tick();
        cfg_dftpts = 12'd60;
        #1;
        chk("t5_dftpts_hold", 64'(out_dftpts), 64'd12);
        drain(100, "t5_drain");
        chk("t5_count", 64'(valid_cnt - v0), 64'd12);

        // 6: reset mid-burst, then a clean frame
        do_reset();
        cfg_dftpts = 12'd12;
        mem_idle   = 1'b1;
        v0 = valid_cnt;
        expect_frame(600, 12);
        push_stream(600, 12);
        for (int i = 0; i < 30 && (valid_cnt - v0) < 5; i++) tick();
        mon_en = 0;
        rst_n  = 1'b0;
        tick();
        chk("t6_outs", {out_valid, out_sop, out_eop, out_real, out_imag, out_dftpts}, 64'd0);
        chk("t6_level", 64'(fifo_level), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1;
        v0 = valid_cnt;
        expect_frame(700, 12);
        push_stream(700, 12);
        drain(100, "t6_drain");
        chk("t6_count", 64'(valid_cnt - v0), 64'd12);
        chk("t6_level_end", 64'(fifo_level), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
